// File: rtl/gbfflgact_reader.sv
// Read-side controller for the GB flag-activation SRAM wrapper.
// Streams a burst of consecutive RAM words to a valid/ready consumer.
// A 2-entry skid FIFO hides the registered read latency and absorbs back-pressure.
module gbfflgact_reader #(
  parameter int SRAM_DEPTH_BIT = 6,
  parameter int SRAM_WIDTH     = 28,
  parameter int LEN_BIT        = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [SRAM_DEPTH_BIT-1:0] base_addr,
  input  logic [LEN_BIT-1:0]        len,
  output logic                      busy,
  output logic                      done,
  output logic [SRAM_DEPTH_BIT-1:0] ram_addr_r,
  output logic                      ram_read_en,
  input  logic [SRAM_WIDTH-1:0]     ram_data_out,
  input  logic                      ram_wr_busy,
  output logic [SRAM_WIDTH-1:0]     out_data,
  output logic                      out_valid,
  input  logic                      out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [SRAM_DEPTH_BIT-1:0] rd_addr;
  logic [LEN_BIT-1:0]        issue_cnt;
  logic [LEN_BIT-1:0]        pop_cnt;
  logic                      inflight;
  logic [SRAM_WIDTH-1:0]     fifo_mem [2];
  logic                      wr_ptr;
  logic                      rd_ptr;
  logic [1:0]                occ;
  logic                      pop;
  logic                      issue;
  logic [2:0]                credit_sum;

  // A read may only issue if, after this cycle's pop, the FIFO plus the word
  // already on its way from the RAM leaves room for one more.
  assign pop        = out_valid & out_ready;
  assign credit_sum = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = rst_n && (state == RUN) && (issue_cnt != '0) &&
                      !ram_wr_busy && (credit_sum < 3'd2);

  assign ram_read_en = issue;
  assign ram_addr_r  = rd_addr;
  assign out_valid   = (occ != 2'd0);
  assign out_data    = fifo_mem[rd_ptr];
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  // Next-state logic: a zero-length burst goes straight to the done pulse.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (len == '0) ? DONE : RUN;
      RUN:  if (pop && (pop_cnt == LEN_BIT'(1))) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus address and burst counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_addr   <= '0;
      issue_cnt <= '0;
      pop_cnt   <= '0;
      inflight  <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= issue;
      if (state == IDLE && start) begin
        rd_addr   <= base_addr;
        issue_cnt <= len;
        pop_cnt   <= len;
      end else begin
        if (issue) begin
          rd_addr   <= rd_addr + SRAM_DEPTH_BIT'(1);
          issue_cnt <= issue_cnt - LEN_BIT'(1);
        end
        if (state == RUN && pop) begin
          pop_cnt <= pop_cnt - LEN_BIT'(1);
        end
      end
    end
  end

  // Skid FIFO: capture the word read last cycle, release the head on pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
    end else begin
      if (inflight) begin
        fifo_mem[wr_ptr] <= ram_data_out;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_gbfflgact_reader.sv
// Self-checking bench for gbfflgact_reader with a behavioural registered RAM.
module tb_gbfflgact_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  base_addr;
  logic [6:0]  len;
  logic        busy;
  logic        done;
  logic [5:0]  ram_addr_r;
  logic        ram_read_en;
  logic [27:0] ram_data_out;
  logic        ram_wr_busy;
  logic [27:0] out_data;
  logic        out_valid;
  logic        out_ready;

  logic [27:0] mem [64];
  logic [27:0] exp_q [$];
  logic [5:0]  addr_q [$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          outstanding = 0;
  logic        hold_valid = 1'b0;
  logic [27:0] hold_data = '0;

  gbfflgact_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .ram_addr_r(ram_addr_r), .ram_read_en(ram_read_en),
    .ram_data_out(ram_data_out), .ram_wr_busy(ram_wr_busy), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // RAM with registered read data.
  always @(posedge clk) begin
    if (ram_read_en) ram_data_out <= mem[ram_addr_r];
  end

  // Scoreboard: checks popped words, issued addresses, credit rule and hold stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
      hold_valid  = 1'b0;
    end else begin
      if (hold_valid) begin
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== hold_data)
          $display("[TB] FAIL hold_stable: got valid=%0b data=%0d, need valid=1 data=%0d", out_valid, out_data, hold_data);
        else pass_cnt++;
      end
      hold_valid = out_valid && !out_ready;
      hold_data  = out_data;
      if (out_valid && out_ready) begin
        total_cnt++;
        if (exp_q.size() == 0)
          $display("[TB] FAIL pop_data: got %0d, need no pop (queue empty)", out_data);
        else begin
          logic [27:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) $display("[TB] FAIL pop_data: got %0d, need %0d", out_data, e);
          else pass_cnt++;
        end
      end
      if (ram_read_en) begin
        total_cnt++;
        if (addr_q.size() == 0)
          $display("[TB] FAIL read_addr: got read at %0d, need no read", ram_addr_r);
        else begin
          logic [5:0] a;
          a = addr_q.pop_front();
          if (ram_addr_r !== a) $display("[TB] FAIL read_addr: got %0d, need %0d", ram_addr_r, a);
          else pass_cnt++;
        end
        total_cnt++;
        if (outstanding - int'(out_valid && out_ready) >= 2)
          $display("[TB] FAIL credit: got occ+inflight-pop=%0d, need <2", outstanding - int'(out_valid && out_ready));
        else pass_cnt++;
      end
      outstanding = outstanding + int'(ram_read_en) - int'(out_valid && out_ready);
    end
  end

  task automatic push_burst(input logic [5:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      logic [5:0] a;
      a = b + 6'(i);
      addr_q.push_back(a);
      exp_q.push_back(mem[a]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0;
    ram_wr_busy = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({busy, done, out_valid, ram_read_en} !== 4'b0 || out_data !== '0 || ram_addr_r !== '0)
      $display("[TB] FAIL reset_outputs: got busy=%0b done=%0b valid=%0b data=%0d en=%0b addr=%0d, need all 0",
               busy, done, out_valid, out_data, ram_read_en, ram_addr_r);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 6'd5; len = 7'd4;
    push_burst(6'd5, 4);
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      total_cnt++;
      if (ram_read_en !== (cyc >= 1 && cyc <= 4))
        $display("[TB] FAIL basic_read_en c%0d: got %0b, need %0b", cyc, ram_read_en, (cyc >= 1 && cyc <= 4));
      else pass_cnt++;
      total_cnt++;
      if (out_valid !== (cyc >= 3 && cyc <= 6))
        $display("[TB] FAIL basic_valid c%0d: got %0b, need %0b", cyc, out_valid, (cyc >= 3 && cyc <= 6));
      else pass_cnt++;
      total_cnt++;
      if (done !== (cyc == 7) || busy !== (cyc <= 7))
        $display("[TB] FAIL basic_done_busy c%0d: got done=%0b busy=%0b, need done=%0b busy=%0b",
                 cyc, done, busy, (cyc == 7), (cyc <= 7));
      else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap();
    int done_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 6'd62; len = 7'd4;
    push_burst(6'd62, 4);
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 20 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (done) done_cyc = cyc;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (done_cyc != 7 || exp_q.size() != 0)
      $display("[TB] FAIL wrap_done: got done cycle %0d left %0d, need cycle 7 left 0", done_cyc, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int done_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 6'd40; len = 7'd8;
    push_burst(6'd40, 8);
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 80 && done_cyc < 0; cyc++) begin
      out_ready = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
      @(negedge clk);
      if (done) done_cyc = cyc;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    total_cnt++;
    if (done_cyc < 0 || exp_q.size() != 0 || addr_q.size() != 0)
      $display("[TB] FAIL bp_complete: got done cycle %0d left %0d, need done and 0 left", done_cyc, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_wr_busy();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 6'd10; len = 7'd4;
    push_burst(6'd10, 4);
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      ram_wr_busy = (cyc == 2 || cyc == 3);
      @(negedge clk);
      total_cnt++;
      if (ram_read_en !== (cyc == 1 || (cyc >= 4 && cyc <= 6)))
        $display("[TB] FAIL wrbusy_read_en c%0d: got %0b, need %0b", cyc, ram_read_en, (cyc == 1 || (cyc >= 4 && cyc <= 6)));
      else pass_cnt++;
      if (cyc == 2 || cyc == 3) begin
        total_cnt++;
        if (ram_addr_r !== 6'd11) $display("[TB] FAIL wrbusy_addr_hold c%0d: got %0d, need 11", cyc, ram_addr_r);
        else pass_cnt++;
      end
      total_cnt++;
      if (done !== (cyc == 9)) $display("[TB] FAIL wrbusy_done c%0d: got %0b, need %0b", cyc, done, (cyc == 9));
      else pass_cnt++;
      @(posedge clk); #1;
    end
    ram_wr_busy = 1'b0;
  endtask

  task automatic test_len0_and_ignore();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 6'd3; len = 7'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b1 || busy !== 1'b1 || ram_read_en !== 1'b0)
      $display("[TB] FAIL len0_c1: got done=%0b busy=%0b en=%0b, need 1 1 0", done, busy, ram_read_en);
    else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL len0_c2: got done=%0b busy=%0b, need 0 0", done, busy);
    else pass_cnt++;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 6'd20; len = 7'd4;
    push_burst(6'd20, 4);
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      start = (cyc == 2);
      base_addr = (cyc == 2) ? 6'd40 : 6'd20;
      len = (cyc == 2) ? 7'd3 : 7'd4;
      @(negedge clk);
      total_cnt++;
      if (done !== (cyc == 7) || busy !== (cyc <= 7))
        $display("[TB] FAIL ignore_done_busy c%0d: got done=%0b busy=%0b, need done=%0b busy=%0b",
                 cyc, done, busy, (cyc == 7), (cyc <= 7));
      else pass_cnt++;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int done_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 6'd30; len = 7'd8;
    push_burst(6'd30, 8);
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      if (cyc == 4) rst_n = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
    end
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    total_cnt++;
    if ({busy, done, out_valid, ram_read_en} !== 4'b0 || out_data !== '0 || ram_addr_r !== '0)
      $display("[TB] FAIL midreset_outputs: got busy=%0b done=%0b valid=%0b data=%0d en=%0b addr=%0d, need all 0",
               busy, done, out_valid, out_data, ram_read_en, ram_addr_r);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      total_cnt++;
      if (done !== 1'b0 || busy !== 1'b0)
        $display("[TB] FAIL midreset_idle: got done=%0b busy=%0b, need 0 0", done, busy);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    start = 1'b1; base_addr = 6'd0; len = 7'd2;
    push_burst(6'd0, 2);
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 20 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (done) done_cyc = cyc;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (done_cyc != 5 || exp_q.size() != 0)
      $display("[TB] FAIL fresh_burst: got done cycle %0d left %0d, need cycle 5 left 0", done_cyc, exp_q.size());
    else pass_cnt++;
  endtask

  // Test sequence.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 28'(i);
    ram_data_out = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_wr_busy();
    test_len0_and_ignore();
    test_reset_mid_burst();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/gbfflgact_reader.md
Name: gbfflgact_reader

Overview:
- Read-side controller for the GB flag-activation SRAM wrapper.
- On a start command, streams a burst of `len` consecutive words from a base address to a downstream consumer using a valid/ready handshake.
- Hides the 1-cycle registered RAM read latency and absorbs consumer back-pressure with an internal 2-entry skid FIFO.
- Yields the shared RAM address port to the writer whenever the writer is writing.

Parameters:
- SRAM_DEPTH_BIT, 6, RAM address width; depth = 2**SRAM_DEPTH_BIT.
- SRAM_WIDTH, 28, RAM word width.
- LEN_BIT, 7, width of burst length; max burst = 2**SRAM_DEPTH_BIT words.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  burst request; sampled only in IDLE.
- base_addr  input  SRAM_DEPTH_BIT  first word address; sampled with start.
- len  input  LEN_BIT  words in burst; sampled with start.
- busy  output  1  high from the cycle after accepted start through the done cycle.
- done  output  1  one-cycle pulse when the burst is complete.
- ram_addr_r  output  SRAM_DEPTH_BIT  RAM read address.
- ram_read_en  output  1  RAM read enable.
- ram_data_out  input  SRAM_WIDTH  RAM registered read data; valid the cycle after ram_read_en.
- ram_wr_busy  input  1  writer's write_en; blocks reads in that cycle.
- out_data  output  SRAM_WIDTH  FIFO head word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts; pop = out_valid & out_ready.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, counters=0, FIFO emptied, in-flight flag cleared.
  - Reset values: busy=0, done=0, out_valid=0, out_data=0, ram_read_en=0, ram_addr_r=0.
  - ram_read_en is also gated combinationally by rst_n.
  - Reset mid-burst aborts it: no done pulse, remaining words discarded.
- States:
  - IDLE: start=1 latches rd_addr=base_addr and issue_cnt=pop_cnt=len. Next state is RUN, or DONE if len=0.
  - RUN: issues reads and pops data. Goes to DONE on the cycle of the last pop (pop_cnt=1 & pop).
  - DONE: done=1 and busy=1 for one cycle, then IDLE. start is ignored in DONE and RUN.
- Read issue (combinational), ram_read_en=1 iff all hold:
  - state=RUN
  - issue_cnt>0
  - ram_wr_busy=0
  - occ + inflight - pop < 2, where occ = FIFO occupancy (0..2) and inflight = read issued last cycle.
- ram_addr_r = rd_addr at all times.
- On issue: rd_addr increments modulo 2**SRAM_DEPTH_BIT (wraps 63->0), and issue_cnt decrements.
- When blocked by ram_wr_busy: address held, retried next cycle, no word lost or duplicated.
- Capture: if inflight=1, ram_data_out is written to the FIFO tail at the posedge.
  - Push and pop in the same cycle keep occ unchanged.
  - The credit rule guarantees no overflow.
- Latency, with start sampled at the end of cycle 0 and out_ready=1:
  - cycle 1: ram_read_en=1, ram_addr_r=base.
  - cycle 2: RAM data valid.
  - cycle 3: out_valid=1 with word 0.
  - Then 1 word/cycle sustained. For len=N, the last word appears in cycle N+2 and done pulses in cycle N+3.
- out_valid, once high, holds with out_data stable until popped.
- len=0: no RAM reads; done pulses in cycle 1.
- len > 2**SRAM_DEPTH_BIT: illegal. Addresses wrap and the RAM is re-read.

Test Plan:
- RAM preloaded mem[i]=i; start base=5, len=4, out_ready=1 -> ram_read_en cycles 1-4 at addrs 5,6,7,8; out_data 5,6,7,8 on cycles 3-6; done=1 at cycle 7 only; busy cycles 1-7.
- base=62, len=4 -> read addrs 62,63,0,1; output 62,63,0,1 in order.
- len=8, out_ready toggling 1,0,0,1,… -> all 8 words in order, no duplicates or drops; ram_read_en never raised with occ+inflight-pop>=2; out_data stable while out_valid&~out_ready.
- len=4, ram_wr_busy=1 in cycles 2-3 -> ram_read_en=0 those cycles, ram_addr_r holds base+1; output sequence unchanged, done delayed by 2 cycles.
- len=0 -> no ram_read_en, done pulses in cycle 1; second start during busy of a len=4 burst is ignored.
- rst_n=0 during cycle 4 of len=8 burst -> next cycle all outputs 0, state IDLE, no done; a fresh start base=0, len=2 afterwards returns mem[0], mem[1].
